// File: rtl/cbd_pkg.sv
// Shared constants and FSM state type for the eta=3 CBD sampling scheduler.
package cbd_pkg;
  localparam int CBD_ETA         = 3;
  localparam int COEF_W          = 12;
  localparam int KYBER_Q         = 3329;
  localparam int WORDS_PER_POLY  = 24;
  localparam int GROUPS_PER_POLY = 64;
  localparam int GROUP_BITS      = 24;
  localparam int WORD_BITS       = 64;
  localparam int BUF_BITS        = 88;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_STREAM,
    ST_DONE
  } cbd_state_t;
endpackage

// File: rtl/cbd_quad.sv
// Combinational eta=3 CBD: 24-bit group -> four 12-bit coefficients.
// With CBD_MODQ_EN defined, outputs are reduced into [0, KYBER_Q).
module cbd_quad
  import cbd_pkg::*;
(
  input  logic [GROUP_BITS-1:0] grp,
  output logic [4*COEF_W-1:0]   coefs
);

  localparam int SW = 2 * CBD_ETA;

  logic [COEF_W-1:0] a;
  logic [COEF_W-1:0] b;
  logic [COEF_W-1:0] d;

  always_comb begin
    coefs = '0;
    a     = '0;
    b     = '0;
    d     = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      a = '0;
      b = '0;
      for (int unsigned i = 0; i < CBD_ETA; i++) begin
        a = a + COEF_W'(grp[SW*j + i]);
        b = b + COEF_W'(grp[SW*j + CBD_ETA + i]);
      end
`ifdef CBD_MODQ_EN
      d = (a < b) ? (a + COEF_W'(KYBER_Q) - b) : (a - b);
`else
      d = a - b;
`endif
      coefs[COEF_W*j +: COEF_W] = d;
    end
  end

endmodule

// File: rtl/cbd_poly_scheduler.sv
// Round-robin scheduler: grants a client, starts the PRF, repacks 64-bit words
// into 24-bit groups and emits 64 CBD coefficient quads. Option: CBD_MODQ_EN.
module cbd_poly_scheduler
  import cbd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int NONCE_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*NONCE_W-1:0]   req_nonce,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           req_done,
  output logic                       prf_start,
  output logic [NONCE_W-1:0]         prf_nonce,
  input  logic                       in_valid,
  input  logic [63:0]                in_data,
  output logic                       in_ready,
  output logic                       coef_valid,
  input  logic                       coef_ready,
  output logic [47:0]                coef_data,
  output logic [5:0]                 coef_addr,
  output logic [$clog2(N_REQ)-1:0]   coef_owner
);

  localparam int OW = $clog2(N_REQ);

  cbd_state_t        state, state_nx;
  logic [OW-1:0]     rr_ptr;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     pick;
  logic              pick_ok;
  logic [BUF_BITS-1:0] bits_q, bits_nx, bits_shift;
  logic [6:0]        cnt, cnt_nx, base;
  logic [4:0]        words_taken;
  logic [5:0]        grp_idx;
  logic              emit, take;
  int unsigned       cand;

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(rr_ptr) + i) % N_REQ;
      if (!pick_ok && req[cand]) begin
        pick_ok = 1'b1;
        pick    = OW'(cand);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    gnt       = '0;
    req_done  = '0;
    prf_start = 1'b0;
    case (state)
      ST_IDLE:   if (pick_ok) state_nx = ST_GRANT;
      ST_GRANT: begin
        gnt[owner] = 1'b1;
        prf_start  = 1'b1;
        state_nx   = ST_STREAM;
      end
      ST_STREAM: if (emit && grp_idx == 6'(GROUPS_PER_POLY - 1)) state_nx = ST_DONE;
      ST_DONE: begin
        req_done[owner] = 1'b1;
        state_nx        = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign coef_valid = (state == ST_STREAM) && (cnt >= 7'(GROUP_BITS));
  assign emit       = coef_valid && coef_ready;
  assign in_ready   = (state == ST_STREAM) && (words_taken < 5'(WORDS_PER_POLY)) &&
                      ((cnt < 7'(GROUP_BITS)) || ((cnt < 7'(2*GROUP_BITS)) && emit));
  assign take       = in_valid && in_ready;

  // Bits above cnt are always zero, so a new word can simply be OR-ed in.
  always_comb begin
    bits_shift = emit ? (bits_q >> GROUP_BITS) : bits_q;
    base       = emit ? (cnt - 7'(GROUP_BITS)) : cnt;
    bits_nx    = take ? (bits_shift | (BUF_BITS'(in_data) << base)) : bits_shift;
    cnt_nx     = take ? (base + 7'(WORD_BITS)) : base;
  end

  // Owner/nonce are captured on entry to GRANT so prf_nonce is valid with prf_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      prf_nonce   <= '0;
      bits_q      <= '0;
      cnt         <= '0;
      words_taken <= '0;
      grp_idx     <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && pick_ok) begin
        owner     <= pick;
        prf_nonce <= req_nonce[32'(pick)*NONCE_W +: NONCE_W];
        rr_ptr    <= (pick == OW'(N_REQ - 1)) ? '0 : pick + 1'b1;
      end
      if (state == ST_GRANT) begin
        bits_q      <= '0;
        cnt         <= '0;
        words_taken <= '0;
        grp_idx     <= '0;
      end else begin
        bits_q <= bits_nx;
        cnt    <= cnt_nx;
        if (take) words_taken <= words_taken + 1'b1;
        if (emit) grp_idx     <= grp_idx + 1'b1;
      end
    end
  end

  assign coef_addr  = grp_idx;
  assign coef_owner = owner;

  cbd_quad u_quad (
    .grp   (bits_q[GROUP_BITS-1:0]),
    .coefs (coef_data)
  );

endmodule

// File: tb/tb_cbd_poly_scheduler.sv
// Scoreboard bench for cbd_poly_scheduler: directed polynomials, round-robin,
// backpressure and mid-stream reset. Honours CBD_MODQ_EN for expected values.
module tb_cbd_poly_scheduler;

  localparam int N  = 4;
  localparam int NW = 8;

`ifdef CBD_MODQ_EN
  localparam logic [11:0] C_NEG3 = 12'hCFE;
  localparam logic [11:0] C_NEG1 = 12'hD00;
`else
  localparam logic [11:0] C_NEG3 = 12'hFFD;
  localparam logic [11:0] C_NEG1 = 12'hFFF;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*NW-1:0] req_nonce;
  logic [N-1:0]    gnt, req_done;
  logic            prf_start;
  logic [NW-1:0]   prf_nonce;
  logic            in_valid, in_ready;
  logic [63:0]     in_data;
  logic            coef_valid, coef_ready;
  logic [47:0]     coef_data;
  logic [5:0]      coef_addr;
  logic [1:0]      coef_owner;

  cbd_poly_scheduler #(.N_REQ(N), .NONCE_W(NW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_nonce(req_nonce),
    .gnt(gnt), .req_done(req_done), .prf_start(prf_start), .prf_nonce(prf_nonce),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_addr(coef_addr), .coef_owner(coef_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic [5:0]  addr;
    int          owner;
  } exp_t;

  exp_t        coef_q[$];
  int          gnt_q[$];
  logic [47:0] exp_grp[64];
  logic [63:0] cur_words[24];
  logic [7:0]  nonce_b[N];
  int errors = 0;
  int checks = 0;
  int widx = 0, words_seen = 0, done_cnt = 0, cur_owner = 0, stall_left = 0;
  bit active = 0, busy = 0, stall_arm = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_poly();
    for (int i = 0; i < 64; i++) exp_grp[i] = '0;
    for (int i = 0; i < 24; i++) cur_words[i] = '0;
  endtask

  task automatic push_poly(input int o);
    for (int g = 0; g < 64; g++) begin
      exp_t e;
      e.data = exp_grp[g];
      e.addr = 6'(g);
      e.owner = o;
      coef_q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_prf_start"}, prf_start, 0);
    chk({tag, "_prf_nonce"}, prf_nonce, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_coef_valid"}, coef_valid, 0);
    chk({tag, "_coef_addr"}, coef_addr, 0);
    chk({tag, "_coef_owner"}, coef_owner, 0);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    chk("req_done_timeout", (done_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic run_single(input int c, input logic [7:0] n);
    int lat;
    int target;
    target = done_cnt + 1;
    nonce_b[c] = n;
    req_nonce[c*NW +: NW] = n;
    gnt_q.push_back(c);
    push_poly(c);
    @(posedge clk); #1;
    req = 4'(1 << c);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == 0 && lat < 100);
    chk("gnt_latency", lat, 2);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("in_ready_first", in_ready, 1);
    wait_done(target);
  endtask

  // PRF word source: word index advances on each observed handshake.
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      in_valid = active;
      in_data  = (widx < 24) ? cur_words[widx] : 64'hA5A5_5A5A_0F0F_F0F0;
    end
  end

  initial begin
    coef_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_arm && coef_valid && coef_addr == 6'd20) begin
        stall_arm  = 0;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        coef_ready = 1'b0;
        stall_left--;
      end else begin
        coef_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (gnt != 0) begin
          if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", gnt, 0);
          end else begin
            int g;
            g = gnt_q.pop_front();
            chk("gnt", gnt, 64'(1) << g);
            chk("prf_start", prf_start, 1);
            chk("prf_nonce", prf_nonce, nonce_b[g]);
            chk("gnt_while_busy", busy, 0);
            chk("in_ready_at_gnt", in_ready, 0);
            cur_owner = g;
            busy = 1;
            active = 1;
            widx = 0;
            words_seen = 0;
          end
        end
        if (in_valid && in_ready) begin
          widx++;
          words_seen++;
        end
        if (coef_valid && !coef_ready && coef_q.size() > 0) begin
          chk("hold_data", coef_data, coef_q[0].data);
          chk("hold_addr", coef_addr, coef_q[0].addr);
        end
        if (!coef_ready && stall_left == 0) begin
          chk("stall_in_ready", in_ready, 0);
          chk("stall_coef_valid", coef_valid, 1);
        end
        if (coef_valid && coef_ready) begin
          if (coef_q.size() == 0) begin
            chk("coef_unexpected", coef_valid, 0);
          end else begin
            exp_t e;
            e = coef_q.pop_front();
            chk($sformatf("coef_data[%0d]", e.addr), coef_data, e.data);
            chk("coef_addr", coef_addr, e.addr);
            chk("coef_owner", coef_owner, e.owner);
          end
        end
        if (req_done != 0) begin
          chk("req_done", req_done, 64'(1) << cur_owner);
          chk("words_per_poly", words_seen, 24);
          busy = 0;
          active = 0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    int target;
    reset = 1'b0;
    req = '0;
    req_nonce = '0;
    for (int i = 0; i < N; i++) nonce_b[i] = '0;
    clear_poly();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // All-zero stream
    clear_poly();
    run_single(0, 8'h05);

    // Single +3 coefficient
    clear_poly();
    cur_words[0] = 64'h7;
    exp_grp[0] = 48'h003;
    run_single(0, 8'hA1);

    // Single -3 coefficient
    clear_poly();
    cur_words[0] = 64'h38;
    exp_grp[0] = {36'h0, C_NEG3};
    run_single(2, 8'h3C);

    // Groups straddling words, with a 10-cycle stall at group 20
    clear_poly();
    cur_words[0] = '1;
    cur_words[2] = 64'h7;
    exp_grp[2] = 48'h000002000000;
    exp_grp[5] = {24'h0, C_NEG1, 12'h0};
    stall_arm = 1;
    run_single(3, 8'hC3);

    // Round-robin with constant req = 1011
    clear_poly();
    nonce_b[0] = 8'h10; nonce_b[1] = 8'h11; nonce_b[3] = 8'h13;
    req_nonce = {8'h13, 8'h00, 8'h11, 8'h10};
    foreach (nonce_b[i]) nonce_b[i] = req_nonce[i*NW +: NW];
    target = done_cnt + 4;
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(3); gnt_q.push_back(0);
    push_poly(0); push_poly(1); push_poly(3); push_poly(0);
    @(posedge clk); #1;
    req = 4'b1011;
    for (int i = 0; i < 2000 && gnt_q.size() > 0; i++) @(negedge clk);
    chk("rr_grants_seen", gnt_q.size(), 0);
    @(posedge clk); #1;
    req = '0;
    wait_done(target);

    // Mid-stream reset at group 30
    clear_poly();
    nonce_b[1] = 8'h22;
    req_nonce[1*NW +: NW] = 8'h22;
    gnt_q.push_back(1);
    push_poly(1);
    @(posedge clk); #1;
    req = 4'b0010;
    for (int i = 0; i < 100 && gnt == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    req = '0;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(coef_valid && coef_ready && coef_addr == 6'd30) && k < 500);
      chk("reached_group30", coef_addr, 30);
    end
    #1;
    reset = 1'b0;
    coef_q.delete();
    gnt_q.delete();
    active = 0;
    busy = 0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh request after reset: pointer back at 0, client 2 drops before grant
    clear_poly();
    nonce_b[2] = 8'h55;
    req_nonce[2*NW +: NW] = 8'h55;
    req_nonce[1*NW +: NW] = 8'h44;
    nonce_b[1] = 8'h44;
    target = done_cnt + 1;
    gnt_q.push_back(1);
    push_poly(1);
    @(posedge clk); #1;
    req = 4'b0110;
    for (int i = 0; i < 100 && gnt == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    req = '0;
    wait_done(target);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", coef_q.size(), 0);
    chk("gnt_queue_empty", gnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
